i2s_tx_engine: RTL and testbench
================================

// Module: i2s_tx_engine
// PURPOSE
//  Parametrised serial audio transmitter for the stereo output DAC.
//  - Pulls one stereo sample {L,R} per frame from a show-ahead FIFO.
//  - Serialises it as BCK/LRCK/DATA in left-justified, I2S or right-justified format.
//  - Fully synchronous to one clock; BCK and LRCK are registered outputs (no derived-clock flops).
//  - Adds underrun detection and soft mute; generalises sample width, slot width and BCK rate.
// PARAMETERS
//  SAMPLE_W      16  bits per channel sample (2..32)
//  SLOT_W        24  BCK periods per channel slot; frame = 2*SLOT_W BCKs
//  BCK_DIV       8   i_clk36 cycles per BCK half-period (>=2); default gives 2.304MHz BCK, 48kHz LRCK
//  FORMAT        0   0=left-justified, 1=I2S (1-BCK delay), 2=right-justified
//  UNDERRUN_MUTE 1   1=send zeros on underrun, 0=repeat last sample
// PORTS
//  i_clk36     in   1           system audio clock, 36.864MHz
//  i_rst36_n   in   1           reset, synchronous, active-low
//  i_empty     in   1           FIFO empty; no read issued while high
//  i_sample    in   2*SAMPLE_W  {L,R}, valid whenever i_empty low (show-ahead)
//  i_mute      in   1           force zero data, sampled at frame start
//  o_rdreq     out  1           1-cycle FIFO read acknowledge
//  o_underrun  out  1           1-cycle pulse: frame fetch found FIFO empty
//  o_bck       out  1           bit clock
//  o_lrck      out  1           word clock, 1 period per frame
//  o_data      out  1           serial data, MSB first
// BEHAVIOUR
//  Reset: all outputs 0.
//  - div_cnt=0, bit_cnt=0, hold/shift registers=0.
//  - Takes effect on the next clock edge, including mid-frame.
//  - First frame after reset transmits zeros.
//  Clocking: div_cnt counts 0..BCK_DIV-1, then wraps; o_bck toggles on each wrap.
//  - o_bck stays low for the first BCK_DIV cycles after reset.
//  - "Fall edge" = the cycle o_bck goes 1->0; "rise edge" = the cycle o_bck goes 0->1.
//  Bit counter: bit_cnt 0..2*SLOT_W-1 advances on each fall edge; wraps to 0 (frame start).
//  - 0..SLOT_W-1 = left slot; SLOT_W..2*SLOT_W-1 = right slot.
//  - Slot position p = bit_cnt mod SLOT_W.
//  Output timing: o_lrck and o_data update only on fall-edge cycles, in the same register update as o_bck.
//  - The DAC samples them on BCK rise.
//  LRCK polarity: FORMAT 0/2 -> o_lrck=1 in left slot; FORMAT 1 -> o_lrck=0 in left slot.
//  - LRCK toggles at p=0 in every format.
//  Data per slot position p:
//  - FORMAT 0: sample bit SAMPLE_W-1-p for p<SAMPLE_W, else 0.
//  - FORMAT 1: 0 at p=0; sample bit SAMPLE_W-p for 1<=p<=SAMPLE_W; else 0.
//  - FORMAT 2: 0 for p<SLOT_W-SAMPLE_W; sample bits MSB..LSB in the last SAMPLE_W positions.
//  Fetch: on the rise-edge cycle of bit_cnt=2*SLOT_W-1 (last bit of the frame):
//  - If !i_empty: o_rdreq=1 for that one cycle; hold <= i_sample.
//  - If i_empty: o_underrun=1 for that one cycle; o_rdreq=0; hold <= 0 (UNDERRUN_MUTE=1) or is kept (UNDERRUN_MUTE=0).
//  - Exactly one fetch attempt per frame; o_rdreq never asserts twice per frame.
//  Frame start (fall edge to bit_cnt=0): L/R shift registers load from hold, or 0 if i_mute=1.
//  - i_mute does not stop FIFO reads.
//  - A FIFO entry that goes non-empty mid-frame waits for the next fetch slot.
//  Latency: i_sample captured at rdreq -> first bit on o_data BCK_DIV cycles later.
//  - This holds for FORMAT 0 at the left-slot start.
//  Elaboration error if SLOT_W<SAMPLE_W+(FORMAT==1) or BCK_DIV<2.
// TESTING
//  1. Defaults, FIFO holds {16'hA5A5,16'h5A5A}:
//     - one rdreq per 768 cycles.
//     - next frame: LRCK=1 slot carries 1010010110100101 then 8 zeros.
//     - LRCK=0 slot carries 0101101001011010 then 8 zeros.
//  2. i_empty held high: o_underrun pulses every 768 cycles and o_rdreq stays 0.
//     - UNDERRUN_MUTE=1 -> all-zero data; UNDERRUN_MUTE=0 -> previous sample repeated.
//  3. FORMAT=1, sample 16'h8001:
//     - LRCK=0 for left; bit after LRCK edge is 0, then 1, fourteen 0s, 1.
//     - LRCK edges 384 cycles apart.
//  4. FORMAT=2, SLOT_W=24, sample 16'hFFFF: eight 0 bits then sixteen 1 bits in each slot.
//  5. Reset pulsed mid-frame (bit_cnt=30):
//     - next cycle all outputs 0; o_bck first rises 8 cycles after release.
//     - first o_rdreq 760 cycles after release.
//  6. i_mute=1 across a frame start with a non-empty FIFO: that frame's data is all zeros.
//     - o_rdreq still pulses once and the FIFO is drained.

Source files
------------

// File: rtl/i2s_tx_engine.sv
// i2s_tx_engine: stereo serial audio transmitter (left-justified / I2S / right-justified).
// One stereo word {L,R} is pulled from a show-ahead FIFO once per frame. BCK, LRCK and
// DATA are plain registers in the i_clk36 domain, so no derived clocks exist.
module i2s_tx_engine #(
    parameter int SAMPLE_W      = 16,
    parameter int SLOT_W        = 24,
    parameter int BCK_DIV       = 8,
    parameter int FORMAT        = 0,
    parameter int UNDERRUN_MUTE = 1
) (
    input  logic                  i_clk36,
    input  logic                  i_rst36_n,
    input  logic                  i_empty,
    input  logic [2*SAMPLE_W-1:0] i_sample,
    input  logic                  i_mute,
    output logic                  o_rdreq,
    output logic                  o_underrun,
    output logic                  o_bck,
    output logic                  o_lrck,
    output logic                  o_data
);

    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int DIV_W      = $clog2(BCK_DIV);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    // First slot position that carries a sample bit.
    localparam int DATA_OFS   = (FORMAT == 0) ? 0 : (FORMAT == 1) ? 1 : SLOT_W - SAMPLE_W;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(BCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] RIGHT_BASE = BIT_W'(SLOT_W);

    // Reject parameter sets that cannot fit the sample into its slot.
    generate
        if (SAMPLE_W < 2 || SAMPLE_W > 32 || BCK_DIV < 2 || FORMAT < 0 || FORMAT > 2 ||
            SLOT_W < SAMPLE_W + ((FORMAT == 1) ? 1 : 0)) begin : g_param_error
            $error("i2s_tx_engine: illegal SAMPLE_W/SLOT_W/BCK_DIV/FORMAT combination");
        end
    endgenerate

    logic [DIV_W-1:0]      div_cnt_reg;
    logic [BIT_W-1:0]      bit_cnt_reg;
    logic                  bck_reg;
    logic                  lrck_reg;
    logic                  data_reg;
    logic                  rdreq_reg;
    logic                  underrun_reg;
    logic [2*SAMPLE_W-1:0] hold_reg;
    logic [SAMPLE_W-1:0]   frame_l_reg;
    logic [SAMPLE_W-1:0]   frame_r_reg;

    logic                  div_wrap;
    logic                  fall_edge;
    logic                  rise_edge;
    logic [BIT_W-1:0]      bit_next;
    logic                  frame_start;
    logic                  left_next;
    logic                  lrck_next;
    logic [SAMPLE_W-1:0]   load_l;
    logic [SAMPLE_W-1:0]   load_r;

    int                    slot_pos;
    logic [SAMPLE_W-1:0]   slot_word;
    logic [SAMPLE_W-1:0]   word_shifted;
    logic                  data_next;

    assign div_wrap    = (div_cnt_reg == DIV_LAST);
    assign fall_edge   = div_wrap & bck_reg;
    assign rise_edge   = div_wrap & ~bck_reg;
    assign bit_next    = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
    assign frame_start = (bit_next == '0);
    assign left_next   = (bit_next < RIGHT_BASE);
    // I2S drives LRCK low during the left slot, the other formats drive it high.
    assign lrck_next   = (FORMAT == 1) ? ~left_next : left_next;
    // Mute is applied only when a frame is loaded; the held sample itself is untouched.
    assign load_l      = i_mute ? '0 : hold_reg[2*SAMPLE_W-1:SAMPLE_W];
    assign load_r      = i_mute ? '0 : hold_reg[SAMPLE_W-1:0];

    // Pick the serial bit that belongs to the slot position entered on this fall edge.
    always_comb begin
        slot_pos     = left_next ? int'(bit_next) : int'(bit_next) - SLOT_W;
        if (frame_start) begin
            slot_word = load_l;
        end else if (left_next) begin
            slot_word = frame_l_reg;
        end else begin
            slot_word = frame_r_reg;
        end
        word_shifted = '0;
        data_next    = 1'b0;
        if (slot_pos >= DATA_OFS && slot_pos < DATA_OFS + SAMPLE_W) begin
            word_shifted = slot_word >> (SAMPLE_W - 1 - slot_pos + DATA_OFS);
            data_next    = word_shifted[0];
        end
    end

    // Clock divider, bit counter, serial outputs and once-per-frame FIFO fetch.
    always_ff @(posedge i_clk36) begin
        if (!i_rst36_n) begin
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            bck_reg      <= 1'b0;
            lrck_reg     <= 1'b0;
            data_reg     <= 1'b0;
            rdreq_reg    <= 1'b0;
            underrun_reg <= 1'b0;
            hold_reg     <= '0;
            frame_l_reg  <= '0;
            frame_r_reg  <= '0;
        end else begin
            div_cnt_reg  <= div_wrap ? '0 : div_cnt_reg + 1'b1;
            rdreq_reg    <= 1'b0;
            underrun_reg <= 1'b0;

            if (div_wrap) begin
                bck_reg <= ~bck_reg;
            end

            // LRCK/DATA change together with BCK falling so the DAC sees them stable on rise.
            if (fall_edge) begin
                bit_cnt_reg <= bit_next;
                lrck_reg    <= lrck_next;
                data_reg    <= data_next;
                if (frame_start) begin
                    frame_l_reg <= load_l;
                    frame_r_reg <= load_r;
                end
            end

            // Fetch on the rise of the last frame bit, half a BCK before the next frame loads.
            if (rise_edge && bit_cnt_reg == BIT_LAST) begin
                if (!i_empty) begin
                    rdreq_reg <= 1'b1;
                    hold_reg  <= i_sample;
                end else begin
                    underrun_reg <= 1'b1;
                    if (UNDERRUN_MUTE != 0) begin
                        hold_reg <= '0;
                    end
                end
            end
        end
    end

    assign o_bck      = bck_reg;
    assign o_lrck     = lrck_reg;
    assign o_data     = data_reg;
    assign o_rdreq    = rdreq_reg;
    assign o_underrun = underrun_reg;

endmodule

// File: tb/tb_i2s_tx_engine.sv
// tb_i2s_tx_engine: four engines (LJ, I2S, RJ, LJ-repeat-on-underrun) share one FIFO model.
// Serial bits are captured on each BCK rise and compared frame by frame with a reference
// that builds each slot as the sample padded and shifted by the format's bit offset.
module tb_i2s_tx_engine;

    localparam int FRAME = 768;
    localparam int MAXB  = 512;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        empty;
    logic [31:0] sample;
    logic        mute;
    logic [3:0]  rdreq_v, underrun_v, bck_v, lrck_v, data_v;

    int cyc = 0, rel_cyc = 0, n_checks = 0, n_fail = 0;
    logic [1:0] cap [4][MAXB];
    int cap_n, first_rise, rd_n, ur_n, lr_n, disagree;
    int rd_st [16];
    int ur_st [16];
    int lr_st [16];
    logic bck_prev, lrck1_prev;
    logic [31:0] fifo_q [$];
    logic [31:0] ent [8];
    int fmt_of [4] = '{0, 1, 2, 0};
    int um_of  [4] = '{1, 1, 1, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_tx_engine u_lj (.i_clk36(clk), .i_rst36_n(rst_n), .i_empty(empty), .i_sample(sample),
        .i_mute(mute), .o_rdreq(rdreq_v[0]), .o_underrun(underrun_v[0]), .o_bck(bck_v[0]),
        .o_lrck(lrck_v[0]), .o_data(data_v[0]));
    i2s_tx_engine #(.FORMAT(1)) u_i2s (.i_clk36(clk), .i_rst36_n(rst_n), .i_empty(empty),
        .i_sample(sample), .i_mute(mute), .o_rdreq(rdreq_v[1]), .o_underrun(underrun_v[1]),
        .o_bck(bck_v[1]), .o_lrck(lrck_v[1]), .o_data(data_v[1]));
    i2s_tx_engine #(.FORMAT(2)) u_rj (.i_clk36(clk), .i_rst36_n(rst_n), .i_empty(empty),
        .i_sample(sample), .i_mute(mute), .o_rdreq(rdreq_v[2]), .o_underrun(underrun_v[2]),
        .o_bck(bck_v[2]), .o_lrck(lrck_v[2]), .o_data(data_v[2]));
    i2s_tx_engine #(.UNDERRUN_MUTE(0)) u_rep (.i_clk36(clk), .i_rst36_n(rst_n), .i_empty(empty),
        .i_sample(sample), .i_mute(mute), .o_rdreq(rdreq_v[3]), .o_underrun(underrun_v[3]),
        .o_bck(bck_v[3]), .o_lrck(lrck_v[3]), .o_data(data_v[3]));

    // Monitor and show-ahead FIFO model, evaluated on the falling clock edge.
    always @(negedge clk) begin : mon
        int st;
        st = cyc - rel_cyc;
        if (bck_v[0] && !bck_prev) begin
            for (int d = 0; d < 4; d++) cap[d][cap_n] = {lrck_v[d], data_v[d]};
            if (cap_n < MAXB - 1) cap_n++;
            if (first_rise < 0) first_rise = st;
        end
        bck_prev = bck_v[0];
        if (lrck_v[1] != lrck1_prev && lr_n < 16) begin
            lr_st[lr_n] = st;
            lr_n++;
        end
        lrck1_prev = lrck_v[1];
        if (rdreq_v !== {4{rdreq_v[0]}} || underrun_v !== {4{underrun_v[0]}}) disagree++;
        if (rdreq_v[0] === 1'b1) begin
            if (rd_n < 16) rd_st[rd_n] = st;
            rd_n++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        if (underrun_v[0] === 1'b1) begin
            if (ur_n < 16) ur_st[ur_n] = st;
            ur_n++;
        end
        empty  = (fifo_q.size() == 0);
        sample = empty ? $urandom : fifo_q[0];
    end

    // Expected serial data of one frame: each slot is the sample padded to 24 bits, moved right
    // by the format's leading-zero count.
    function automatic logic [47:0] exp_data_vec(int fmt, logic [31:0] w);
        int off;
        logic [23:0] l, r;
        off = (fmt == 0) ? 0 : (fmt == 1) ? 1 : 8;
        l = {w[31:16], 8'h00} >> off;
        r = {w[15:0], 8'h00} >> off;
        return {l, r};
    endfunction

    function automatic logic [47:0] exp_lrck_vec(int fmt);
        return (fmt == 1) ? {24'h000000, 24'hFFFFFF} : {24'hFFFFFF, 24'h000000};
    endfunction

    // Word sent in frame f: frame f-1's fetch result, zero if that frame start was muted.
    function automatic logic [31:0] model_word(int d, int f, int n, int mf);
        logic [31:0] h;
        h = '0;
        for (int g = 1; g <= f; g++) begin
            if (g - 1 < n) h = ent[g - 1];
            else if (um_of[d] != 0) h = '0;
        end
        if (f == 0 || f == mf) return '0;
        return h;
    endfunction

    function automatic logic [47:0] get_frame_data(int d, int f);
        logic [47:0] v;
        for (int k = 0; k < 48; k++) v[47 - k] = cap[d][48 * f + k][0];
        return v;
    endfunction

    function automatic logic [47:0] get_frame_lrck(int d, int f);
        logic [47:0] v;
        for (int k = 0; k < 48; k++) v[47 - k] = cap[d][48 * f + k][1];
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(int st);
        while ((cyc - rel_cyc) < st) step();
    endtask

    task automatic clear_mon();
        cap_n = 0; first_rise = -1; rd_n = 0; ur_n = 0; lr_n = 0; disagree = 0;
        bck_prev = 1'b0; lrck1_prev = 1'b0;
    endtask

    // Reset all engines, preload n entries, release; stamps count cycles from release.
    task automatic start(int n);
        step();
        rst_n = 1'b0;
        mute  = 1'b0;
        repeat (3) step();
        fifo_q.delete();
        for (int i = 0; i < n; i++) fifo_q.push_back(ent[i]);
        empty  = (fifo_q.size() == 0);
        sample = empty ? 32'h0 : fifo_q[0];
        clear_mon();
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic test_reset();
        step();
        rst_n = 1'b0;
        repeat (3) step();
        n_checks++; if (rdreq_v !== 4'h0) begin n_fail++; $display("FAIL reset_rdreq: got %b expected 0000", rdreq_v); end
        n_checks++; if (underrun_v !== 4'h0) begin n_fail++; $display("FAIL reset_underrun: got %b expected 0000", underrun_v); end
        n_checks++; if (bck_v !== 4'h0) begin n_fail++; $display("FAIL reset_bck: got %b expected 0000", bck_v); end
        n_checks++; if (lrck_v !== 4'h0) begin n_fail++; $display("FAIL reset_lrck: got %b expected 0000", lrck_v); end
        n_checks++; if (data_v !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %b expected 0000", data_v); end
        $display("test_reset: outputs checked under reset");
    endtask

    task automatic test_left_justified();
        logic [47:0] ed, el;
        ent[0] = 32'hA5A5_5A5A; ent[1] = $urandom; ent[2] = $urandom;
        start(3);
        run_to(3 * FRAME);
        n_checks++; if (rd_n != 3) begin n_fail++; $display("FAIL lj_rdreq_count: got %0d expected 3", rd_n); end
        for (int i = 0; i < 3 && i < rd_n; i++) begin
            n_checks++; if (rd_st[i] != 760 + FRAME * i) begin n_fail++; $display("FAIL lj_rdreq_time%0d: got %0d expected %0d", i, rd_st[i], 760 + FRAME * i); end
        end
        n_checks++; if (ur_n != 0) begin n_fail++; $display("FAIL lj_underrun_count: got %0d expected 0", ur_n); end
        n_checks++; if (get_frame_data(0, 1) !== 48'hA5A500_5A5A00) begin n_fail++; $display("FAIL lj_pattern_data: got %h expected a5a5005a5a00", get_frame_data(0, 1)); end
        n_checks++; if (get_frame_lrck(0, 1) !== 48'hFFFFFF_000000) begin n_fail++; $display("FAIL lj_pattern_lrck: got %h expected ffffff000000", get_frame_lrck(0, 1)); end
        for (int d = 0; d < 4; d++) for (int f = 0; f < 3; f++) begin
            ed = exp_data_vec(fmt_of[d], model_word(d, f, 3, -1));
            el = exp_lrck_vec(fmt_of[d]); if (f == 0) el[47] = 1'b0;
            n_checks++; if (get_frame_data(d, f) !== ed) begin n_fail++; $display("FAIL lj_data dut%0d frame%0d: got %h expected %h", d, f, get_frame_data(d, f), ed); end
            n_checks++; if (get_frame_lrck(d, f) !== el) begin n_fail++; $display("FAIL lj_lrck dut%0d frame%0d: got %h expected %h", d, f, get_frame_lrck(d, f), el); end
        end
        n_checks++; if (disagree != 0 || fifo_q.size() != 0) begin n_fail++; $display("FAIL lj_drain: disagree %0d fifo %0d expected 0 0", disagree, fifo_q.size()); end
        $display("test_left_justified: 3 frames, %0d rdreq", rd_n);
    endtask

    task automatic test_underrun();
        logic [47:0] ed;
        ent[0] = $urandom;
        start(1);
        run_to(4 * FRAME);
        n_checks++; if (rd_n != 1) begin n_fail++; $display("FAIL ur_rdreq_count: got %0d expected 1", rd_n); end
        n_checks++; if (ur_n != 3) begin n_fail++; $display("FAIL ur_count: got %0d expected 3", ur_n); end
        for (int i = 0; i < 3 && i < ur_n; i++) begin
            n_checks++; if (ur_st[i] != 760 + FRAME * (i + 1)) begin n_fail++; $display("FAIL ur_time%0d: got %0d expected %0d", i, ur_st[i], 760 + FRAME * (i + 1)); end
        end
        n_checks++; if (get_frame_data(0, 2) !== 48'h0) begin n_fail++; $display("FAIL ur_mute_zero: got %h expected 0", get_frame_data(0, 2)); end
        ed = exp_data_vec(0, ent[0]);
        n_checks++; if (get_frame_data(3, 3) !== ed) begin n_fail++; $display("FAIL ur_repeat: got %h expected %h", get_frame_data(3, 3), ed); end
        for (int d = 0; d < 4; d++) for (int f = 1; f < 4; f++) begin
            ed = exp_data_vec(fmt_of[d], model_word(d, f, 1, -1));
            n_checks++; if (get_frame_data(d, f) !== ed) begin n_fail++; $display("FAIL ur_data dut%0d frame%0d: got %h expected %h", d, f, get_frame_data(d, f), ed); end
        end
        $display("test_underrun: %0d underrun pulses", ur_n);
    endtask

    task automatic test_i2s();
        logic [47:0] ed;
        ent[0] = {16'h8001, 16'($urandom)}; ent[1] = $urandom;
        start(2);
        run_to(2 * FRAME);
        n_checks++; if (get_frame_data(1, 1) !== {24'h400080, exp_data_vec(1, ent[0])[23:0]}) begin n_fail++; $display("FAIL i2s_left_bits: got %h expected %h", get_frame_data(1, 1), {24'h400080, exp_data_vec(1, ent[0])[23:0]}); end
        n_checks++; if (get_frame_lrck(1, 1) !== 48'h000000_FFFFFF) begin n_fail++; $display("FAIL i2s_lrck: got %h expected 000000ffffff", get_frame_lrck(1, 1)); end
        n_checks++; if (lr_n < 3) begin n_fail++; $display("FAIL i2s_lrck_edges: got %0d expected >=3", lr_n); end
        for (int i = 0; i < 3 && i < lr_n; i++) begin
            n_checks++; if (lr_st[i] != 384 * (i + 1)) begin n_fail++; $display("FAIL i2s_lrck_edge%0d: got %0d expected %0d", i, lr_st[i], 384 * (i + 1)); end
        end
        ed = exp_data_vec(1, ent[1]);
        run_to(3 * FRAME);
        n_checks++; if (get_frame_data(1, 2) !== ed) begin n_fail++; $display("FAIL i2s_frame2: got %h expected %h", get_frame_data(1, 2), ed); end
        $display("test_i2s: sample %h", ent[0]);
    endtask

    task automatic test_right_justified();
        logic [47:0] ed;
        ent[0] = 32'hFFFF_FFFF; ent[1] = $urandom;
        start(2);
        run_to(3 * FRAME);
        n_checks++; if (get_frame_data(2, 1) !== 48'h00FFFF_00FFFF) begin n_fail++; $display("FAIL rj_ones: got %h expected 00ffff00ffff", get_frame_data(2, 1)); end
        ed = exp_data_vec(2, ent[1]);
        n_checks++; if (get_frame_data(2, 2) !== ed) begin n_fail++; $display("FAIL rj_random: got %h expected %h", get_frame_data(2, 2), ed); end
        $display("test_right_justified: sample %h", ent[1]);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) ent[i] = $urandom;
        start(3);
        run_to(30 * 16 + 4);
        n_checks++; if (lrck_v[1] !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_lrck: got %b expected 1", lrck_v[1]); end
        rst_n = 1'b0;
        step();
        n_checks++; if ({rdreq_v, underrun_v, bck_v, lrck_v, data_v} !== 20'h0) begin n_fail++; $display("FAIL midrst_outputs: got %h expected 00000", {rdreq_v, underrun_v, bck_v, lrck_v, data_v}); end
        clear_mon();
        rst_n   = 1'b1;
        rel_cyc = cyc;
        run_to(FRAME);
        n_checks++; if (first_rise != 8) begin n_fail++; $display("FAIL midrst_first_bck: got %0d expected 8", first_rise); end
        n_checks++; if (rd_n != 1 || rd_st[0] != 760) begin n_fail++; $display("FAIL midrst_first_rdreq: got count %0d at %0d expected 1 at 760", rd_n, rd_st[0]); end
        $display("test_mid_reset: first rise %0d, first rdreq %0d", first_rise, rd_st[0]);
    endtask

    task automatic test_mute();
        logic [47:0] ed;
        for (int i = 0; i < 3; i++) ent[i] = $urandom | 32'h0001_0001;
        start(3);
        run_to(2 * FRAME - 300);
        mute = 1'b1;
        run_to(2 * FRAME + 300);
        mute = 1'b0;
        run_to(3 * FRAME);
        n_checks++; if (rd_n != 3 || fifo_q.size() != 0) begin n_fail++; $display("FAIL mute_drain: got rdreq %0d fifo %0d expected 3 0", rd_n, fifo_q.size()); end
        n_checks++; if (get_frame_data(0, 2) !== 48'h0) begin n_fail++; $display("FAIL mute_zero: got %h expected 0", get_frame_data(0, 2)); end
        for (int d = 0; d < 4; d++) for (int f = 1; f < 3; f++) begin
            ed = exp_data_vec(fmt_of[d], model_word(d, f, 3, 2));
            n_checks++; if (get_frame_data(d, f) !== ed) begin n_fail++; $display("FAIL mute_data dut%0d frame%0d: got %h expected %h", d, f, get_frame_data(d, f), ed); end
        end
        $display("test_mute: frame 2 muted, %0d rdreq", rd_n);
    endtask

    task automatic test_random();
        logic [47:0] ed, el;
        int n, mf, nr;
        for (int it = 0; it < 3; it++) begin
            n  = $urandom_range(0, 4);
            mf = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 3));
            for (int i = 0; i < 8; i++) ent[i] = $urandom;
            start(n);
            if (mf > 0) begin
                run_to(mf * FRAME - 200);
                mute = 1'b1;
                run_to(mf * FRAME + 200);
                mute = 1'b0;
            end
            run_to(4 * FRAME);
            nr = (n < 4) ? n : 4;
            n_checks++; if (rd_n != nr || ur_n != 4 - nr) begin n_fail++; $display("FAIL rnd_fetch it%0d: got rd %0d ur %0d expected %0d %0d", it, rd_n, ur_n, nr, 4 - nr); end
            n_checks++; if (disagree != 0) begin n_fail++; $display("FAIL rnd_agree it%0d: got %0d expected 0", it, disagree); end
            for (int d = 0; d < 4; d++) for (int f = 0; f < 4; f++) begin
                ed = exp_data_vec(fmt_of[d], model_word(d, f, n, mf));
                el = exp_lrck_vec(fmt_of[d]); if (f == 0) el[47] = 1'b0;
                n_checks++; if (get_frame_data(d, f) !== ed) begin n_fail++; $display("FAIL rnd_data it%0d dut%0d frame%0d: got %h expected %h", it, d, f, get_frame_data(d, f), ed); end
                n_checks++; if (get_frame_lrck(d, f) !== el) begin n_fail++; $display("FAIL rnd_lrck it%0d dut%0d frame%0d: got %h expected %h", it, d, f, get_frame_lrck(d, f), el); end
            end
            $display("test_random it%0d: entries %0d mute frame %0d", it, n, mf);
        end
    endtask

    initial begin
        rst_n = 1'b0; mute = 1'b0; empty = 1'b1; sample = '0;
        clear_mon();
        test_reset();
        test_left_justified();
        test_underrun();
        test_i2s();
        test_right_justified();
        test_mid_reset();
        test_mute();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Time limit so a stuck run still terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
